// File: rtl/video_timing_gen.sv
// 15 kHz video timing: line/frame counters, raw syncs and a two-stage pipeline that
// lines up sync, blanking, frame pulse and 3-3-3 colour on the same clock edge.
module video_timing_gen #(
    parameter int unsigned H_TOTAL      = 384,
    parameter int unsigned H_ACTIVE     = 256,
    parameter int unsigned H_SYNC_START = 288,
    parameter int unsigned H_SYNC_LEN   = 29,
    parameter int unsigned V_TOTAL      = 312,
    parameter int unsigned V_ACTIVE     = 256,
    parameter int unsigned V_SYNC_START = 280,
    parameter int unsigned V_SYNC_LEN   = 3
) (
    input  logic       clkvideo,
    input  logic       reset,
    output logic [9:0] hcount,
    output logic [8:0] vcount,
    output logic       de,
    input  logic [2:0] ri,
    input  logic [2:0] gi,
    input  logic [2:0] bi,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       csync_n,
    output logic       frame_start
);
    // One extra bit so sums such as start+len never truncate in the compares.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 32'd1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_SYNC_START);
    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 32'd1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_SYNC_START);
    localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC_START + V_SYNC_LEN);

    logic [9:0]  hcount_r;
    logic [8:0]  vcount_r;
    logic [10:0] hcount_ext_s;
    logic [9:0]  vcount_ext_s;
    logic        h_s;
    logic        v_s;
    logic        c_s;
    logic        de_s;
    logic        frame0_s;
    logic        h1_r;
    logic        v1_r;
    logic        c1_r;
    logic        de1_r;
    logic        frame0_r;

    assign hcount_ext_s = {1'b0, hcount_r};
    assign vcount_ext_s = {1'b0, vcount_r};

    // Pixel and line counters; the line advances on the pixel wrap.
    always_ff @(posedge clkvideo) begin
        if (reset) begin
            hcount_r <= 10'd0;
            vcount_r <= 9'd0;
        end else if (hcount_ext_s == H_LAST) begin
            hcount_r <= 10'd0;
            if (vcount_ext_s == V_LAST) begin
                vcount_r <= 9'd0;
            end else begin
                vcount_r <= vcount_r + 9'd1;
            end
        end else begin
            hcount_r <= hcount_r + 10'd1;
        end
    end

    // Stage-0 raw syncs and display enable decoded from the counters.
    always_comb begin
        h_s      = (hcount_ext_s >= H_SYNC_BEG) && (hcount_ext_s < H_SYNC_END);
        v_s      = (vcount_ext_s >= V_SYNC_BEG) && (vcount_ext_s < V_SYNC_END);
        c_s      = h_s ^ v_s;
        de_s     = (hcount_ext_s < H_ACT) && (vcount_ext_s < V_ACT);
        frame0_s = (hcount_r == 10'd0) && (vcount_r == 9'd0);
    end

    assign hcount = hcount_r;
    assign vcount = vcount_r;
    assign de     = de_s;

    // Stage 1: hold decoded timing while the pixel for these coordinates is fetched.
    always_ff @(posedge clkvideo) begin
        if (reset) begin
            h1_r     <= 1'b0;
            v1_r     <= 1'b0;
            c1_r     <= 1'b0;
            de1_r    <= 1'b0;
            frame0_r <= 1'b0;
        end else begin
            h1_r     <= h_s;
            v1_r     <= v_s;
            c1_r     <= c_s;
            de1_r    <= de_s;
            frame0_r <= frame0_s;
        end
    end

    // Stage 2: registered outputs; colour is blanked outside the active window.
    always_ff @(posedge clkvideo) begin
        if (reset) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            csync_n     <= 1'b1;
            frame_start <= 1'b0;
            ro          <= 3'd0;
            go          <= 3'd0;
            bo          <= 3'd0;
        end else begin
            hsync_n     <= ~h1_r;
            vsync_n     <= ~v1_r;
            csync_n     <= ~c1_r;
            frame_start <= frame0_r;
            if (de1_r) begin
                ro <= ri;
                go <= gi;
                bo <= bi;
            end else begin
                ro <= 3'd0;
                go <= 3'd0;
                bo <= 3'd0;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a default-parameter instance and a small
// instance, exercised one at a time while the other is held in reset.
module tb_video_timing_gen;
    logic       clkvideo = 1'b0;
    logic       rst_s    = 1'b1;
    logic       sel_s    = 1'b0;
    logic [8:0] rgb_s    = 9'h1FF;
    logic       rst_a_s, rst_b_s;

    logic [9:0] a_hc, b_hc, o_hc;
    logic [8:0] a_vc, b_vc, o_vc;
    logic       a_de, b_de, o_de;
    logic [2:0] a_r, a_g, a_b, b_r, b_g, b_b;
    logic [8:0] o_rgb;
    logic       a_hs, a_vs, a_cs, a_fs, b_hs, b_vs, b_cs, b_fs;
    logic       o_hs, o_vs, o_cs, o_fs;

    always #5 clkvideo = ~clkvideo;

    assign rst_a_s = sel_s ? 1'b1 : rst_s;
    assign rst_b_s = sel_s ? rst_s : 1'b1;

    video_timing_gen dut_a (
        .clkvideo(clkvideo), .reset(rst_a_s), .hcount(a_hc), .vcount(a_vc), .de(a_de),
        .ri(rgb_s[8:6]), .gi(rgb_s[5:3]), .bi(rgb_s[2:0]), .ro(a_r), .go(a_g), .bo(a_b),
        .hsync_n(a_hs), .vsync_n(a_vs), .csync_n(a_cs), .frame_start(a_fs)
    );

    video_timing_gen #(
        .H_TOTAL(128), .H_ACTIVE(64), .H_SYNC_START(80), .H_SYNC_LEN(12),
        .V_TOTAL(10), .V_ACTIVE(8), .V_SYNC_START(9), .V_SYNC_LEN(1)
    ) dut_b (
        .clkvideo(clkvideo), .reset(rst_b_s), .hcount(b_hc), .vcount(b_vc), .de(b_de),
        .ri(rgb_s[8:6]), .gi(rgb_s[5:3]), .bi(rgb_s[2:0]), .ro(b_r), .go(b_g), .bo(b_b),
        .hsync_n(b_hs), .vsync_n(b_vs), .csync_n(b_cs), .frame_start(b_fs)
    );

    assign o_hc  = sel_s ? b_hc : a_hc;
    assign o_vc  = sel_s ? b_vc : a_vc;
    assign o_de  = sel_s ? b_de : a_de;
    assign o_rgb = sel_s ? {b_r, b_g, b_b} : {a_r, a_g, a_b};
    assign o_hs  = sel_s ? b_hs : a_hs;
    assign o_vs  = sel_s ? b_vs : a_vs;
    assign o_cs  = sel_s ? b_cs : a_cs;
    assign o_fs  = sel_s ? b_fs : a_fs;

    typedef struct packed {
        logic       hs_n;
        logic       vs_n;
        logic       cs_n;
        logic       fs;
        logic [8:0] rgb;
    } exp_t;

    typedef struct packed {
        int   first;
        int   last;
        int   period;
        int   low;
        int   run;
        int   falls;
        logic prev;
    } trk_t;

    exp_t       exp_q[$];
    trk_t       hs_t, vs_t, fs_t;
    int         total_cnt = 0;
    int         bad_cnt   = 0;
    int         cyc       = 0;
    int         serr      = 0;
    int         mx, my;
    int         ht, ha, hss, hsl, vt, va, vss, vsl;
    logic [8:0] nxt_rgb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic trk_t trk_init();
        trk_t t;
        t.first  = -1;
        t.last   = -1;
        t.period = -1;
        t.low    = -1;
        t.run    = 0;
        t.falls  = 0;
        t.prev   = 1'b1;
        return t;
    endfunction

    // Records first fall, fall-to-fall period and low-pulse width of an active-low signal.
    function automatic trk_t trk_upd(input trk_t t, input logic v, input int c);
        if (t.prev && !v) begin
            if (t.falls == 0) t.first = c;
            else t.period = c - t.last;
            t.last = c;
            t.falls++;
        end
        if (!v) t.run++;
        else if (!t.prev) begin
            t.low = t.run;
            t.run = 0;
        end
        t.prev = v;
        return t;
    endfunction

    task automatic cycle_body();
        exp_t       e;
        logic       h, v, dv;
        logic [8:0] rgb_next;
        rgb_s = nxt_rgb;
        check_eq("hcount", 32'(o_hc), 32'(mx));
        check_eq("vcount", 32'(o_vc), 32'(my));
        dv = (mx < ha) && (my < va);
        check_eq("de", 32'(o_de), 32'(dv));
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'(exp_q.size()), 32'd2);
        end else begin
            e = exp_q.pop_front();
            check_eq("hsync_n", 32'(o_hs), 32'(e.hs_n));
            check_eq("vsync_n", 32'(o_vs), 32'(e.vs_n));
            check_eq("csync_n", 32'(o_cs), 32'(e.cs_n));
            check_eq("frame_start", 32'(o_fs), 32'(e.fs));
            check_eq("rgb", 32'(o_rgb), 32'(e.rgb));
        end
        hs_t = trk_upd(hs_t, o_hs, cyc);
        vs_t = trk_upd(vs_t, o_vs, cyc);
        fs_t = trk_upd(fs_t, ~o_fs, cyc);
        if (!o_vs) begin
            if (o_cs !== ~o_hs) serr++;
        end else if (o_cs !== o_hs) serr++;
        // Expected outputs two cycles ahead; the input pixel is x of this cycle one clock later.
        h        = (mx >= hss) && (mx < hss + hsl);
        v        = (my >= vss) && (my < vss + vsl);
        rgb_next = (sel_s || my != 0) ? 9'(mx) : 9'h1FF;
        e.hs_n   = ~h;
        e.vs_n   = ~v;
        e.cs_n   = ~(h ^ v);
        e.fs     = (mx == 0) && (my == 0);
        e.rgb    = dv ? rgb_next : 9'd0;
        exp_q.push_back(e);
        nxt_rgb  = rgb_next;
        mx++;
        if (mx == ht) begin
            mx = 0;
            my++;
            if (my == vt) my = 0;
        end
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            cycle_body();
            @(posedge clkvideo);
            #1;
        end
    endtask

    task automatic apply_reset(input int n);
        rst_s = 1'b1;
        repeat (n) begin
            @(posedge clkvideo);
            #1;
        end
        rst_s = 1'b0;
        mx    = 0;
        my    = 0;
        cyc   = 0;
        serr  = 0;
        exp_q.delete();
        exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b0, 9'd0});
        exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b0, 9'd0});
        nxt_rgb = sel_s ? 9'd0 : 9'h1FF;
        hs_t  = trk_init();
        vs_t  = trk_init();
        fs_t  = trk_init();
    endtask

    initial begin
        int k;
        // Default parameters: reset fill, horizontal timing, blanking and alignment.
        ht = 384; ha = 256; hss = 288; hsl = 29; vt = 312; va = 256; vss = 280; vsl = 3;
        apply_reset(5);
        run_cycles(1200);
        check_eq("a_hs_first", 32'(hs_t.first), 32'd290);
        check_eq("a_hs_period", 32'(hs_t.period), 32'd384);
        check_eq("a_hs_low", 32'(hs_t.low), 32'd29);
        check_eq("a_fs_first", 32'(fs_t.first), 32'd2);
        check_eq("a_fs_count", 32'(fs_t.falls), 32'd1);
        check_eq("a_csync_rel", 32'(serr), 32'd0);

        // Small frame: wraps, vsync on the last line, serration, mid-frame reset.
        sel_s = 1'b1;
        ht = 128; ha = 64; hss = 80; hsl = 12; vt = 10; va = 8; vss = 9; vsl = 1;
        apply_reset(3);
        run_cycles(3840);
        check_eq("b_hs_first", 32'(hs_t.first), 32'd82);
        check_eq("b_hs_period", 32'(hs_t.period), 32'd128);
        check_eq("b_hs_low", 32'(hs_t.low), 32'd12);
        check_eq("b_vs_first", 32'(vs_t.first), 32'd1154);
        check_eq("b_vs_period", 32'(vs_t.period), 32'd1280);
        check_eq("b_vs_low", 32'(vs_t.low), 32'd128);
        check_eq("b_fs_period", 32'(fs_t.period), 32'd1280);
        check_eq("b_csync_rel", 32'(serr), 32'd0);

        k = 0;
        while (!(my == 9 && mx == 20) && k < 2000) begin
            cycle_body();
            @(posedge clkvideo);
            #1;
            k++;
        end
        check_eq("b_reach_vline", 32'(k < 2000), 32'd1);
        check_eq("b_vs_pre_rst", 32'(o_vs), 32'd0);
        cycle_body();
        apply_reset(1);
        check_eq("b_vs_after_rst", 32'(o_vs), 32'd1);
        run_cycles(1300);
        check_eq("b_vs_first_rst", 32'(vs_t.first), 32'd1154);
        check_eq("b_fs_first_rst", 32'(fs_t.first), 32'd2);
        check_eq("b_csync_rel2", 32'(serr), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
